// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one uart_tx_fsm transmitter between NUM_REQ byte
//               producers. Requesters present bytes on valid/ready
//               handshakes; the arbiter grants round-robin, one byte per
//               grant. It drives the transmitter through tx_start/tx_data
//               and watches tx_busy to find the end of each frame. After a
//               frame it waits GAP_CYCLES idle (tx_busy low) cycles before
//               the next grant.
//
// Parameters  : NUM_REQ    - number of requesters (2..8)
//               GAP_CYCLES - idle cycles between frame end and next grant
//               ID_W       - width of grant_id
//
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-high reset
//               req_valid  - per-requester byte valid
//               req_data   - requester i byte in bits [8i+7:8i]
//               req_last   - last byte of a message (message lock only)
//               req_ready  - one-hot accept strobe (combinational)
//               tx_start   - to uart_tx_fsm, held until tx_busy is seen
//               tx_data    - to uart_tx_fsm, stable for the whole frame
//               tx_busy    - from uart_tx_fsm
//               grant_id   - requester owning the current/last frame
//               active     - high from grant until the frame (and gap) ends
//
// Options     : `define UART_ARB_LOCK_EN enables the message lock: once a
//               requester's byte is accepted with req_last low, only that
//               requester is considered until its req_last byte is taken.
//               Without the macro req_last is ignored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 2,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active
);

  // Gap counter must hold the value GAP_CYCLES (its reset value).
  localparam int c_gap_w = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [c_gap_w-1:0] c_gap_init = c_gap_w'(GAP_CYCLES);
  localparam logic [c_gap_w-1:0] c_gap_last =
      c_gap_w'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [NUM_REQ-1:0] c_one     = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    c_rr_init = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_tx_start;
  logic [7:0]           r_tx_data;
  logic [ID_W-1:0]      r_grant_id;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [c_gap_w-1:0]   r_gap_cnt;

  logic [NUM_REQ-1:0]   w_cand;
  logic                 w_found;
  logic [ID_W-1:0]      w_pick;
  logic                 w_grant;
  logic [7:0]           w_pick_data;

  // --------------------------------------------------------------------------
  // Candidate set: all valid requesters, or only the locked owner.
  // --------------------------------------------------------------------------
`ifdef UART_ARB_LOCK_EN
  logic r_locked;

  always_comb begin
    w_cand = req_valid;
    if (r_locked) begin
      w_cand = req_valid & (c_one << r_grant_id);
    end
  end

  // The lock follows the req_last flag of each accepted byte: a byte without
  // req_last keeps (or establishes) ownership for its requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked <= 1'b0;
    end else if (w_grant) begin
      r_locked <= ~req_last[w_pick];
    end
  end
`else
  assign w_cand = req_valid;

  // req_last has no function without the message lock.
  logic w_unused_last;
  assign w_unused_last = ^req_last;
`endif

  // --------------------------------------------------------------------------
  // Round-robin pick: first candidate searching cyclically from rr_ptr+1.
  // --------------------------------------------------------------------------
  always_comb begin : p_pick
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && w_cand[idx]) begin
        w_found = 1'b1;
        w_pick  = ID_W'(idx);
      end
    end
  end

  // Reset is included so that no strobe escapes while the state is forced.
  assign w_grant     = (r_state == ST_IDLE) && !tx_busy && !rst && w_found;
  assign req_ready   = w_grant ? (c_one << w_pick) : '0;
  assign w_pick_data = req_data[8*int'(w_pick) +: 8];

  // --------------------------------------------------------------------------
  // Control FSM with registered transmitter outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_grant_id <= '0;
      r_rr_ptr   <= c_rr_init;
      r_gap_cnt  <= c_gap_init;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_tx_data  <= w_pick_data;
            r_grant_id <= w_pick;
            r_rr_ptr   <= w_pick;
            r_tx_start <= 1'b1;
            r_state    <= ST_START;
          end
        end

        // tx_start is a level held until the transmitter reports busy.
        ST_START: begin
          if (tx_busy) begin
            r_tx_start <= 1'b0;
            r_state    <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            if (GAP_CYCLES == 0) begin
              r_state <= ST_IDLE;
            end else begin
              r_gap_cnt <= '0;
              r_state   <= ST_GAP;
            end
          end
        end

        // Only cycles with the transmitter idle count towards the gap; a
        // foreign user raising tx_busy freezes the count.
        ST_GAP: begin
          if (!tx_busy) begin
            if (r_gap_cnt == c_gap_last) begin
              r_gap_cnt <= c_gap_init;
              r_state   <= ST_IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_tx_start <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign grant_id = r_grant_id;
  assign active   = (r_state != ST_IDLE);

endmodule
`default_nettype wire
